// File: rtl/lsu_mem_arbiter_if.sv
// Bundle of LSU-side and memory-side signals around lsu_mem_arbiter.
// The master modport is the arbiter's view; slave is the LSU/memory environment.
interface lsu_mem_arbiter_if #(
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 2,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8
);
   logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
   logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
   logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
   logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
   logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
   logic [NUM_CONSUMERS-1:0]           consumer_write_ready;
   logic [NUM_CHANNELS-1:0]            mem_read_valid;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
   logic [NUM_CHANNELS-1:0]            mem_read_ready;
   logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;
   logic [NUM_CHANNELS-1:0]            mem_write_valid;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address;
   logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data;
   logic [NUM_CHANNELS-1:0]            mem_write_ready;

   modport master (
      input  consumer_read_valid, consumer_read_address,
      output consumer_read_ready, consumer_read_data,
      input  consumer_write_valid, consumer_write_address, consumer_write_data,
      output consumer_write_ready,
      output mem_read_valid, mem_read_address,
      input  mem_read_ready, mem_read_data,
      output mem_write_valid, mem_write_address, mem_write_data,
      input  mem_write_ready
   );

   modport slave (
      output consumer_read_valid, consumer_read_address,
      input  consumer_read_ready, consumer_read_data,
      output consumer_write_valid, consumer_write_address, consumer_write_data,
      input  consumer_write_ready,
      input  mem_read_valid, mem_read_address,
      output mem_read_ready, mem_read_data,
      input  mem_write_valid, mem_write_address, mem_write_data,
      output mem_write_ready
   );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter from per-thread LSU read/write ports onto NUM_CHANNELS memory
// channels; each channel owns at most one consumer and relays its response back.
module lsu_mem_arbiter #(
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 2,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8
) (
   input logic               clk,
   input logic               reset,
   lsu_mem_arbiter_if.master bus
);
   localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      READ_WAITING  = 2'd1,
      WRITE_WAITING = 2'd2,
      RELAYING      = 2'd3
   } state_e;

   state_e                   state_q [NUM_CHANNELS];
   state_e                   state_d [NUM_CHANNELS];
   logic [CW-1:0]            cons_q  [NUM_CHANNELS];
   logic [CW-1:0]            cons_d  [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] busy_q, busy_d;
   logic [CW-1:0]            rr_ptr_q, rr_ptr_d;

   logic [NUM_CHANNELS-1:0]  mem_read_valid_q, mem_read_valid_d;
   logic [NUM_CHANNELS-1:0]  mem_write_valid_q, mem_write_valid_d;
   logic [ADDR_BITS-1:0]     mem_read_address_q  [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     mem_read_address_d  [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     mem_write_address_q [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     mem_write_address_d [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     mem_write_data_q    [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     mem_write_data_d    [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] consumer_read_ready_q, consumer_read_ready_d;
   logic [NUM_CONSUMERS-1:0] consumer_write_ready_q, consumer_write_ready_d;
   logic [DATA_BITS-1:0]     consumer_read_data_q [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]     consumer_read_data_d [NUM_CONSUMERS];

   logic [ADDR_BITS-1:0]     rd_addr_s [NUM_CONSUMERS];
   logic [ADDR_BITS-1:0]     wr_addr_s [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]     wr_data_s [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]     mem_rdata_s [NUM_CHANNELS];

   // Unpack the flat consumer and memory buses into per-index arrays.
   always_comb begin
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
         rd_addr_s[i] = bus.consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
         wr_addr_s[i] = bus.consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
         wr_data_s[i] = bus.consumer_write_data[i*DATA_BITS +: DATA_BITS];
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         mem_rdata_s[c] = bus.mem_read_data[c*DATA_BITS +: DATA_BITS];
      end
   end

   // Per-channel FSM next state; channels grant in index order so lower channels claim first.
   always_comb begin : arb_comb
      logic [NUM_CONSUMERS-1:0] claimed_s;
      logic [CW:0]              sum_s;
      logic [CW-1:0]            idx_s;
      logic [CW-1:0]            sel_s;
      logic                     found_s;

      state_d                = state_q;
      cons_d                 = cons_q;
      busy_d                 = busy_q;
      rr_ptr_d               = rr_ptr_q;
      mem_read_valid_d       = mem_read_valid_q;
      mem_write_valid_d      = mem_write_valid_q;
      mem_read_address_d     = mem_read_address_q;
      mem_write_address_d    = mem_write_address_q;
      mem_write_data_d       = mem_write_data_q;
      consumer_read_ready_d  = consumer_read_ready_q;
      consumer_write_ready_d = consumer_write_ready_q;
      consumer_read_data_d   = consumer_read_data_q;
      claimed_s              = busy_q;
      sum_s                  = '0;
      idx_s                  = '0;
      sel_s                  = '0;
      found_s                = 1'b0;

      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         case (state_q[ch])
            IDLE: begin
               found_s = 1'b0;
               sel_s   = '0;
               for (int k = 0; k < NUM_CONSUMERS; k++) begin
                  sum_s = {1'b0, rr_ptr_q} + (CW+1)'(k);
                  if (sum_s >= (CW+1)'(NUM_CONSUMERS)) begin
                     sum_s = sum_s - (CW+1)'(NUM_CONSUMERS);
                  end else begin
                     sum_s = sum_s;
                  end
                  idx_s = sum_s[CW-1:0];
                  if (!found_s && !claimed_s[idx_s] &&
                      (bus.consumer_read_valid[idx_s] || bus.consumer_write_valid[idx_s])) begin
                     found_s = 1'b1;
                     sel_s   = idx_s;
                  end else begin
                     found_s = found_s;
                  end
               end
               if (found_s) begin
                  claimed_s[sel_s] = 1'b1;
                  busy_d[sel_s]    = 1'b1;
                  cons_d[ch]       = sel_s;
                  if (bus.consumer_read_valid[sel_s]) begin
                     mem_read_valid_d[ch]   = 1'b1;
                     mem_read_address_d[ch] = rd_addr_s[sel_s];
                     state_d[ch]            = READ_WAITING;
                  end else begin
                     mem_write_valid_d[ch]   = 1'b1;
                     mem_write_address_d[ch] = wr_addr_s[sel_s];
                     mem_write_data_d[ch]    = wr_data_s[sel_s];
                     state_d[ch]             = WRITE_WAITING;
                  end
                  // Later channels overwrite this, leaving the highest granting channel's successor.
                  sum_s = {1'b0, sel_s} + {{CW{1'b0}}, 1'b1};
                  if (sum_s >= (CW+1)'(NUM_CONSUMERS)) begin
                     rr_ptr_d = '0;
                  end else begin
                     rr_ptr_d = sum_s[CW-1:0];
                  end
               end else begin
                  state_d[ch] = IDLE;
               end
            end
            READ_WAITING: begin
               if (bus.mem_read_ready[ch]) begin
                  mem_read_valid_d[ch]                  = 1'b0;
                  consumer_read_data_d[cons_q[ch]]      = mem_rdata_s[ch];
                  consumer_read_ready_d[cons_q[ch]]     = 1'b1;
                  state_d[ch]                           = RELAYING;
               end else begin
                  state_d[ch] = READ_WAITING;
               end
            end
            WRITE_WAITING: begin
               if (bus.mem_write_ready[ch]) begin
                  mem_write_valid_d[ch]              = 1'b0;
                  consumer_write_ready_d[cons_q[ch]] = 1'b1;
                  state_d[ch]                        = RELAYING;
               end else begin
                  state_d[ch] = WRITE_WAITING;
               end
            end
            RELAYING: begin
               if (consumer_read_ready_q[cons_q[ch]] && !bus.consumer_read_valid[cons_q[ch]]) begin
                  consumer_read_ready_d[cons_q[ch]] = 1'b0;
                  busy_d[cons_q[ch]]                = 1'b0;
                  state_d[ch]                       = IDLE;
               end else if (consumer_write_ready_q[cons_q[ch]] &&
                            !bus.consumer_write_valid[cons_q[ch]]) begin
                  consumer_write_ready_d[cons_q[ch]] = 1'b0;
                  busy_d[cons_q[ch]]                 = 1'b0;
                  state_d[ch]                        = IDLE;
               end else begin
                  state_d[ch] = RELAYING;
               end
            end
            default: begin
               state_d[ch] = IDLE;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_q[ch]             <= IDLE;
            cons_q[ch]              <= '0;
            mem_read_address_q[ch]  <= '0;
            mem_write_address_q[ch] <= '0;
            mem_write_data_q[ch]    <= '0;
         end
         for (int i = 0; i < NUM_CONSUMERS; i++) begin
            consumer_read_data_q[i] <= '0;
         end
         busy_q                 <= '0;
         rr_ptr_q               <= '0;
         mem_read_valid_q       <= '0;
         mem_write_valid_q      <= '0;
         consumer_read_ready_q  <= '0;
         consumer_write_ready_q <= '0;
      end else begin
         state_q                <= state_d;
         cons_q                 <= cons_d;
         mem_read_address_q     <= mem_read_address_d;
         mem_write_address_q    <= mem_write_address_d;
         mem_write_data_q       <= mem_write_data_d;
         consumer_read_data_q   <= consumer_read_data_d;
         busy_q                 <= busy_d;
         rr_ptr_q               <= rr_ptr_d;
         mem_read_valid_q       <= mem_read_valid_d;
         mem_write_valid_q      <= mem_write_valid_d;
         consumer_read_ready_q  <= consumer_read_ready_d;
         consumer_write_ready_q <= consumer_write_ready_d;
      end
   end

   assign bus.mem_read_valid       = mem_read_valid_q;
   assign bus.mem_write_valid      = mem_write_valid_q;
   assign bus.consumer_read_ready  = consumer_read_ready_q;
   assign bus.consumer_write_ready = consumer_write_ready_q;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      assign bus.mem_read_address[c*ADDR_BITS +: ADDR_BITS]  = mem_read_address_q[c];
      assign bus.mem_write_address[c*ADDR_BITS +: ADDR_BITS] = mem_write_address_q[c];
      assign bus.mem_write_data[c*DATA_BITS +: DATA_BITS]    = mem_write_data_q[c];
   end

   for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_cons
      assign bus.consumer_read_data[i*DATA_BITS +: DATA_BITS] = consumer_read_data_q[i];
   end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: one task per scenario with hand-computed expectations.
module tb_lsu_mem_arbiter;
   localparam int NC = 4;
   localparam int NH = 2;
   localparam int AB = 8;
   localparam int DB = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   lsu_mem_arbiter_if #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NH), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

   lsu_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NH), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.consumer_read_valid    = '0;
      bus.consumer_read_address  = '0;
      bus.consumer_write_valid   = '0;
      bus.consumer_write_address = '0;
      bus.consumer_write_data    = '0;
      bus.mem_read_ready         = '0;
      bus.mem_read_data          = '0;
      bus.mem_write_ready        = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.mem_read_valid !== 2'b00) begin bad++; $display("FAIL reset_mem_rv: got %b want 00", bus.mem_read_valid); end
      total++; if (bus.mem_write_valid !== 2'b00) begin bad++; $display("FAIL reset_mem_wv: got %b want 00", bus.mem_write_valid); end
      total++; if (bus.consumer_read_ready !== 4'b0000) begin bad++; $display("FAIL reset_crr: got %b want 0000", bus.consumer_read_ready); end
      total++; if (bus.consumer_write_ready !== 4'b0000) begin bad++; $display("FAIL reset_cwr: got %b want 0000", bus.consumer_write_ready); end
      total++; if (bus.consumer_read_data !== 32'h0) begin bad++; $display("FAIL reset_crd: got %h want 0", bus.consumer_read_data); end
      total++; if (bus.mem_read_address !== 16'h0) begin bad++; $display("FAIL reset_mra: got %h want 0", bus.mem_read_address); end
      tick();
      total++; if (bus.mem_read_valid !== 2'b00) begin bad++; $display("FAIL idle_mem_rv: got %b want 00", bus.mem_read_valid); end
   endtask

   task automatic test_single_read();
      do_reset();
      bus.consumer_read_valid[0] = 1'b1;
      bus.consumer_read_address[7:0] = 8'h12;
      tick();
      total++; if (bus.mem_read_valid !== 2'b01) begin bad++; $display("FAIL rd_grant: got %b want 01", bus.mem_read_valid); end
      total++; if (bus.mem_read_address[7:0] !== 8'h12) begin bad++; $display("FAIL rd_addr: got %h want 12", bus.mem_read_address[7:0]); end
      total++; if (bus.consumer_read_ready !== 4'b0000) begin bad++; $display("FAIL rd_early_ready: got %b want 0000", bus.consumer_read_ready); end
      bus.mem_read_ready[0] = 1'b1;
      bus.mem_read_data[7:0] = 8'hA5;
      tick();
      bus.mem_read_ready = '0;
      total++; if (bus.consumer_read_ready !== 4'b0001) begin bad++; $display("FAIL rd_ready: got %b want 0001", bus.consumer_read_ready); end
      total++; if (bus.consumer_read_data[7:0] !== 8'hA5) begin bad++; $display("FAIL rd_data: got %h want a5", bus.consumer_read_data[7:0]); end
      total++; if (bus.mem_read_valid !== 2'b00) begin bad++; $display("FAIL rd_valid_drop: got %b want 00", bus.mem_read_valid); end
      tick();
      total++; if (bus.consumer_read_ready !== 4'b0001) begin bad++; $display("FAIL rd_ready_hold: got %b want 0001", bus.consumer_read_ready); end
      bus.consumer_read_valid[0] = 1'b0;
      tick();
      total++; if (bus.consumer_read_ready !== 4'b0000) begin bad++; $display("FAIL rd_ready_release: got %b want 0000", bus.consumer_read_ready); end
      total++; if (bus.consumer_read_data[7:0] !== 8'hA5) begin bad++; $display("FAIL rd_data_hold: got %h want a5", bus.consumer_read_data[7:0]); end
   endtask

   task automatic test_single_write();
      do_reset();
      bus.consumer_write_valid[2] = 1'b1;
      bus.consumer_write_address[23:16] = 8'h40;
      bus.consumer_write_data[23:16] = 8'h7E;
      tick();
      total++; if (bus.mem_write_valid !== 2'b01) begin bad++; $display("FAIL wr_grant: got %b want 01", bus.mem_write_valid); end
      total++; if (bus.mem_write_address[7:0] !== 8'h40) begin bad++; $display("FAIL wr_addr: got %h want 40", bus.mem_write_address[7:0]); end
      total++; if (bus.mem_write_data[7:0] !== 8'h7E) begin bad++; $display("FAIL wr_data: got %h want 7e", bus.mem_write_data[7:0]); end
      total++; if (bus.mem_read_valid !== 2'b00) begin bad++; $display("FAIL wr_no_read: got %b want 00", bus.mem_read_valid); end
      bus.mem_write_ready[0] = 1'b1;
      tick();
      bus.mem_write_ready = '0;
      total++; if (bus.consumer_write_ready !== 4'b0100) begin bad++; $display("FAIL wr_ack: got %b want 0100", bus.consumer_write_ready); end
      total++; if (bus.mem_write_valid !== 2'b00) begin bad++; $display("FAIL wr_valid_drop: got %b want 00", bus.mem_write_valid); end
      bus.consumer_write_valid[2] = 1'b0;
      tick();
      total++; if (bus.consumer_write_ready !== 4'b0000) begin bad++; $display("FAIL wr_ack_release: got %b want 0000", bus.consumer_write_ready); end
      total++; if (bus.consumer_read_ready !== 4'b0000) begin bad++; $display("FAIL wr_no_read_ack: got %b want 0000", bus.consumer_read_ready); end
   endtask

   task automatic test_contention();
      do_reset();
      bus.consumer_read_valid = 4'b1111;
      bus.consumer_read_address = 32'h13121110;
      tick();
      total++; if (bus.mem_read_valid !== 2'b11) begin bad++; $display("FAIL ct_grant1: got %b want 11", bus.mem_read_valid); end
      total++; if (bus.mem_read_address !== 16'h1110) begin bad++; $display("FAIL ct_addr1: got %h want 1110", bus.mem_read_address); end
      total++; if (dut.rr_ptr_q !== 2'd2) begin bad++; $display("FAIL ct_rr_ptr: got %0d want 2", dut.rr_ptr_q); end
      bus.mem_read_ready = 2'b11;
      bus.mem_read_data = 16'hC1C0;
      tick();
      bus.mem_read_ready = '0;
      total++; if (bus.consumer_read_ready !== 4'b0011) begin bad++; $display("FAIL ct_ready1: got %b want 0011", bus.consumer_read_ready); end
      total++; if (bus.consumer_read_data[15:0] !== 16'hC1C0) begin bad++; $display("FAIL ct_data1: got %h want c1c0", bus.consumer_read_data[15:0]); end
      bus.consumer_read_valid[1:0] = 2'b00;
      tick();
      total++; if (bus.consumer_read_ready !== 4'b0000) begin bad++; $display("FAIL ct_release1: got %b want 0000", bus.consumer_read_ready); end
      tick();
      total++; if (bus.mem_read_valid !== 2'b11) begin bad++; $display("FAIL ct_grant2: got %b want 11", bus.mem_read_valid); end
      total++; if (bus.mem_read_address !== 16'h1312) begin bad++; $display("FAIL ct_addr2: got %h want 1312", bus.mem_read_address); end
      bus.mem_read_ready = 2'b11;
      bus.mem_read_data = 16'hC3C2;
      tick();
      bus.mem_read_ready = '0;
      total++; if (bus.consumer_read_ready !== 4'b1100) begin bad++; $display("FAIL ct_ready2: got %b want 1100", bus.consumer_read_ready); end
      total++; if (bus.consumer_read_data !== 32'hC3C2C1C0) begin bad++; $display("FAIL ct_data2: got %h want c3c2c1c0", bus.consumer_read_data); end
      bus.consumer_read_valid = '0;
      tick();
      total++; if (bus.consumer_read_ready !== 4'b0000) begin bad++; $display("FAIL ct_release2: got %b want 0000", bus.consumer_read_ready); end
   endtask

   task automatic test_rw_priority();
      do_reset();
      bus.consumer_read_valid[1] = 1'b1;
      bus.consumer_write_valid[1] = 1'b1;
      bus.consumer_read_address[15:8] = 8'h21;
      bus.consumer_write_address[15:8] = 8'h31;
      bus.consumer_write_data[15:8] = 8'h5A;
      tick();
      total++; if (bus.mem_read_valid !== 2'b01) begin bad++; $display("FAIL pr_read_first: got %b want 01", bus.mem_read_valid); end
      total++; if (bus.mem_write_valid !== 2'b00) begin bad++; $display("FAIL pr_no_write: got %b want 00", bus.mem_write_valid); end
      total++; if (bus.mem_read_address[7:0] !== 8'h21) begin bad++; $display("FAIL pr_raddr: got %h want 21", bus.mem_read_address[7:0]); end
      bus.mem_read_ready[0] = 1'b1;
      bus.mem_read_data[7:0] = 8'h99;
      tick();
      bus.mem_read_ready = '0;
      total++; if (bus.consumer_read_ready !== 4'b0010) begin bad++; $display("FAIL pr_rready: got %b want 0010", bus.consumer_read_ready); end
      bus.consumer_read_valid[1] = 1'b0;
      tick();
      total++; if (bus.mem_write_valid !== 2'b00) begin bad++; $display("FAIL pr_write_held: got %b want 00", bus.mem_write_valid); end
      total++; if (bus.consumer_read_ready !== 4'b0000) begin bad++; $display("FAIL pr_rrelease: got %b want 0000", bus.consumer_read_ready); end
      tick();
      total++; if (bus.mem_write_valid !== 2'b01) begin bad++; $display("FAIL pr_write_grant: got %b want 01", bus.mem_write_valid); end
      total++; if (bus.mem_write_address[7:0] !== 8'h31) begin bad++; $display("FAIL pr_waddr: got %h want 31", bus.mem_write_address[7:0]); end
      total++; if (bus.mem_write_data[7:0] !== 8'h5A) begin bad++; $display("FAIL pr_wdata: got %h want 5a", bus.mem_write_data[7:0]); end
      bus.mem_write_ready[0] = 1'b1;
      tick();
      bus.mem_write_ready = '0;
      total++; if (bus.consumer_write_ready !== 4'b0010) begin bad++; $display("FAIL pr_wack: got %b want 0010", bus.consumer_write_ready); end
      bus.consumer_write_valid[1] = 1'b0;
      tick();
      total++; if (bus.consumer_write_ready !== 4'b0000) begin bad++; $display("FAIL pr_wrelease: got %b want 0000", bus.consumer_write_ready); end
   endtask

   task automatic test_mem_stall();
      do_reset();
      bus.consumer_read_valid[3] = 1'b1;
      bus.consumer_read_address[31:24] = 8'h77;
      tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         total++; if (bus.mem_read_valid !== 2'b01) begin bad++; $display("FAIL st_valid[%0d]: got %b want 01", i, bus.mem_read_valid); end
         total++; if (bus.mem_read_address[7:0] !== 8'h77) begin bad++; $display("FAIL st_addr[%0d]: got %h want 77", i, bus.mem_read_address[7:0]); end
         total++; if (bus.consumer_read_ready !== 4'b0000) begin bad++; $display("FAIL st_ready[%0d]: got %b want 0000", i, bus.consumer_read_ready); end
      end
      bus.mem_read_ready[0] = 1'b1;
      bus.mem_read_data[7:0] = 8'h3C;
      tick();
      bus.mem_read_ready = '0;
      total++; if (bus.consumer_read_ready !== 4'b1000) begin bad++; $display("FAIL st_done: got %b want 1000", bus.consumer_read_ready); end
      total++; if (bus.consumer_read_data[31:24] !== 8'h3C) begin bad++; $display("FAIL st_data: got %h want 3c", bus.consumer_read_data[31:24]); end
      bus.consumer_read_valid[3] = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.consumer_read_valid[0] = 1'b1;
      bus.consumer_read_address[7:0] = 8'h55;
      tick();
      total++; if (bus.mem_read_valid !== 2'b01) begin bad++; $display("FAIL rm_pre: got %b want 01", bus.mem_read_valid); end
      reset = 1'b1;
      bus.consumer_read_valid[0] = 1'b0;
      tick();
      reset = 1'b0;
      total++; if (bus.mem_read_valid !== 2'b00) begin bad++; $display("FAIL rm_rv: got %b want 00", bus.mem_read_valid); end
      total++; if (bus.mem_read_address !== 16'h0) begin bad++; $display("FAIL rm_addr: got %h want 0", bus.mem_read_address); end
      bus.mem_read_ready[0] = 1'b1;
      bus.mem_read_data[7:0] = 8'hEE;
      tick();
      bus.mem_read_ready = '0;
      total++; if (bus.consumer_read_ready !== 4'b0000) begin bad++; $display("FAIL rm_no_ready: got %b want 0000", bus.consumer_read_ready); end
      total++; if (bus.consumer_read_data !== 32'h0) begin bad++; $display("FAIL rm_no_data: got %h want 0", bus.consumer_read_data); end
      tick();
      total++; if (bus.consumer_read_ready !== 4'b0000) begin bad++; $display("FAIL rm_still_quiet: got %b want 0000", bus.consumer_read_ready); end
      total++; if (bus.mem_read_valid !== 2'b00) begin bad++; $display("FAIL rm_no_mem: got %b want 00", bus.mem_read_valid); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_rw_priority();
      test_mem_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
